// File: rtl/ram_arbiter.sv
// Four-requester SDRAM arbiter: fixed priority with CPU anti-starvation override,
// one access in flight, per-access timeout with sticky error flag.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic         clk_sys,
    input  logic         nRESET,
    input  logic [3:0]   req,
    input  logic [3:0]   req_we,
    input  logic [99:0]  req_addr,
    input  logic [31:0]  req_din,
    output logic [3:0]   ack,
    output logic [7:0]   rdata,
    output logic [24:0]  mem_addr,
    output logic [7:0]   mem_din,
    output logic         mem_we,
    output logic         mem_rd,
    input  logic [7:0]   mem_dout,
    input  logic         mem_done,
    output logic         busy,
    output logic [1:0]   grant_id,
    output logic         timeout_err
);

    localparam int          TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]  STARVE  = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg;
    logic [2:0]      cpu_wait_reg;
    logic            we_reg;
    logic [1:0]      winner;
    logic            access_end;

    logic [24:0] addr_arr [4];
    logic [7:0]  din_arr  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*25 +: 25];
            assign din_arr[gi]  = req_din[gi*8 +: 8];
        end
    endgenerate

    // Lowest index wins unless the CPU has already been passed over STARVE_LIMIT times.
    always_comb begin
        winner = 2'd3;
        for (int i = 2; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
        if (req[3] && cpu_wait_reg == STARVE) winner = 2'd3;
    end

    assign access_end = mem_done || (timer_reg == T_LAST);

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE:    if (|req) state_next = ACCESS;
            ACCESS: begin
                busy = 1'b1;
                if (access_end) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            ack          <= '0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_we       <= 1'b0;
            mem_rd       <= 1'b0;
            grant_id     <= '0;
            timeout_err  <= 1'b0;
            cpu_wait_reg <= '0;
            timer_reg    <= '0;
            we_reg       <= 1'b0;
        end else begin
            ack <= '0;
            case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (!req[3]) cpu_wait_reg <= '0;
                    if (|req) begin
                        grant_id <= winner;
                        mem_addr <= addr_arr[winner];
                        mem_din  <= din_arr[winner];
                        we_reg   <= req_we[winner];
                        mem_we   <= req_we[winner];
                        mem_rd   <= ~req_we[winner];
                        if (winner == 2'd3)
                            cpu_wait_reg <= '0;
                        else if (req[3] && cpu_wait_reg < STARVE)
                            cpu_wait_reg <= cpu_wait_reg + 3'd1;
                    end
                end
                ACCESS: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (access_end) begin
                        mem_we <= 1'b0;
                        mem_rd <= 1'b0;
                        ack    <= 4'b0001 << grant_id;
                        // A late completion on the final timer cycle still counts as success.
                        if (mem_done) begin
                            if (!we_reg) rdata <= mem_dout;
                        end else begin
                            timeout_err <= 1'b1;
                            if (!we_reg) rdata <= 8'hFF;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter: a driver predicts each grant from the
// arbitration rules and queues the expected access; a monitor checks the bus and acks.
module tb_ram_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic         clk_sys = 1'b0;
    logic         nRESET;
    logic [3:0]   req, req_we;
    logic [99:0]  req_addr;
    logic [31:0]  req_din;
    logic [3:0]   ack;
    logic [7:0]   rdata;
    logic [24:0]  mem_addr;
    logic [7:0]   mem_din;
    logic         mem_we, mem_rd;
    logic [7:0]   mem_dout;
    logic         mem_done;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout_err;

    always #5 clk_sys = ~clk_sys;

    ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .nRESET(nRESET), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .ack(ack), .rdata(rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_done(mem_done), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int          id;
        logic [24:0] addr;
        logic [7:0]  din;
        logic        we;
        logic [7:0]  rdata;
        logic        terr;
        int          slen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    int          cw = 0;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_terr = 1'b0;
    logic [24:0] r_addr [4];
    logic [7:0]  r_din  [4];
    logic        r_we   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic finish_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*25 +: 25] = r_addr[i];
            req_din[i*8 +: 8]    = r_din[i];
            req_we[i]            = r_we[i];
        end
    endtask

    task automatic raise(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && !req[i]) begin
                r_addr[i] = 25'($urandom);
                r_din[i]  = 8'($urandom);
                r_we[i]   = 1'($urandom);
                req[i]    = 1'b1;
            end
        end
        pack();
    endtask

    function automatic int pick(input logic [3:0] p);
        if (p[3] && cw == STARVE_LIMIT) return 3;
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Called at a falling edge while the DUT is idle or acknowledging; returns at the
    // falling edge of the cycle in which this access is acknowledged.
    task automatic do_txn(input int delay, input logic [3:0] keep_mask, input bit drop_early,
                          input bit allow_new, input logic [3:0] init_set, input int dval);
        int          w, c;
        bit          seen, fin;
        exp_t        e;
        logic [7:0]  dv;
        logic [3:0]  p;
        if (req == 4'b0000) raise((init_set == 4'b0000) ? 4'($urandom_range(1, 15)) : init_set);
        p = req;
        w = pick(p);
        if (!p[3] || w == 3) cw = 0;
        else if (cw < STARVE_LIMIT) cw++;
        dv = (dval < 0) ? 8'($urandom) : 8'(dval);
        if (!r_we[w]) m_rdata = (delay == 0) ? 8'hFF : dv;
        if (delay == 0) m_terr = 1'b1;
        e.id = w; e.addr = r_addr[w]; e.din = r_din[w]; e.we = r_we[w];
        e.rdata = m_rdata; e.terr = m_terr; e.slen = (delay == 0) ? TIMEOUT : delay;
        sb.push_back(e);

        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk_sys);
            seen = mem_rd | mem_we;
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL strobe_wait actual=none required=strobe id=%0d", w);
            finish_up();
        end

        c = 1; fin = 1'b0;
        while (!fin) begin
            if (c == 1 && allow_new) raise(4'($urandom) & ~(4'b0001 << w));
            if (c == 1 && drop_early) req[w] = 1'b0;
            if (c == delay) begin mem_done = 1'b1; mem_dout = dv; end
            @(negedge clk_sys);
            mem_done = 1'b0;
            mem_dout = 8'($urandom);
            if (c == delay || c == TIMEOUT) fin = 1'b1;
            c++;
        end

        seen = (ack != 4'b0000);
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk_sys);
            seen = (ack != 4'b0000);
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL ack_wait actual=none required=ack id=%0d", w);
            finish_up();
        end
        if (!keep_mask[w]) req[w] = 1'b0;
    endtask

    // Monitor: bus-side and ack-side checks against the scoreboard front entry.
    initial begin
        int   scnt;
        bit   sprev;
        exp_t e;
        scnt = 0; sprev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!mon_en) begin
                sprev = 1'b0; scnt = 0;
            end else begin
                chk("strobe_excl", 32'(mem_we & mem_rd), 32'd0);
                chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
                if (mem_we | mem_rd) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe actual=strobe required=none");
                    end else if (!sprev) begin
                        chk("mem_addr", mem_addr, sb[0].addr);
                        chk("mem_din", mem_din, sb[0].din);
                        chk("mem_we", mem_we, sb[0].we);
                        chk("mem_rd", mem_rd, !sb[0].we);
                        chk("grant_id_access", grant_id, sb[0].id);
                        chk("busy_access", busy, 1);
                    end else begin
                        chk("mem_addr_hold", mem_addr, sb[0].addr);
                    end
                    scnt = sprev ? scnt + 1 : 1;
                end else if (sprev && sb.size() > 0) begin
                    chk("strobe_len", scnt, sb[0].slen);
                end
                if (ack != 4'b0000) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack actual=%0h required=0", ack);
                    end else begin
                        e = sb.pop_front();
                        $display("txn id=%0d we=%0d addr=%0h rdata=%0h terr=%0d", e.id, e.we, e.addr, rdata, timeout_err);
                        chk("ack", ack, 32'(1) << e.id);
                        chk("grant_id", grant_id, e.id);
                        chk("rdata", rdata, e.rdata);
                        chk("timeout_err", timeout_err, e.terr);
                        chk("busy_done", busy, 1);
                        chk("strobe_off_done", 32'(mem_we | mem_rd), 0);
                    end
                end
                sprev = mem_we | mem_rd;
            end
        end
    end

    initial begin
        #2_000_000;
        errors++; checks++;
        $display("FAIL watchdog actual=running required=finished");
        finish_up();
    end

    initial begin
        int exp_order [5];
        bit seen;
        nRESET = 1'b1; req = '0; req_we = '0; req_addr = '0; req_din = '0;
        mem_done = 1'b0; mem_dout = '0;
        for (int i = 0; i < 4; i++) begin r_addr[i] = '0; r_din[i] = '0; r_we[i] = 1'b0; end
        #3 nRESET = 1'b0;
        #4;
        chk("rst_ack", ack, 0);        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_we, mem_rd}, 0);
        chk("rst_grant", grant_id, 0); chk("rst_terr", timeout_err, 0);
        @(negedge clk_sys); @(negedge clk_sys);
        nRESET = 1'b1;
        @(negedge clk_sys);

        // Reset in the middle of an FDD read aborts without ack
        r_we[2] = 1'b0; r_addr[2] = 25'h1ABCD; r_din[2] = 8'h11; req = 4'b0100; pack();
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin @(negedge clk_sys); seen = mem_rd; end
        chk("fdd_strobe", 32'(seen), 1);
        @(negedge clk_sys);
        nRESET = 1'b0;
        #1;
        chk("abort_mem_rd", mem_rd, 0); chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);       chk("abort_terr", timeout_err, 0);
        chk("abort_addr", mem_addr, 0);
        req = 4'b0000; pack();
        @(negedge clk_sys); nRESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sys);
            chk("abort_no_ack", ack, 0); chk("abort_idle", busy, 0);
        end
        cw = 0; m_rdata = 8'h00; m_terr = 1'b0;
        mon_en = 1'b1;

        // CPU read, completion in the 4th strobe cycle
        r_we[3] = 1'b0; r_addr[3] = 25'h05_4000; r_din[3] = 8'h00; req = 4'b1000; pack();
        do_txn(4, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5);

        // Tape write that never completes; rdata must keep the CPU value
        r_we[1] = 1'b1; r_addr[1] = 25'h00_0123; r_din[1] = 8'h5A; req = 4'b0010; pack();
        do_txn(0, 4'b0000, 1'b0, 1'b0, 4'b0000, -1);

        // Completion exactly on the last timer cycle is a success
        r_we[0] = 1'b0; r_addr[0] = 25'h1FF_FFFF; r_din[0] = 8'h77; req = 4'b0001; pack();
        do_txn(TIMEOUT, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h3E);

        for (int n = 0; n < 40; n++) begin
            int d;
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
            do_txn(d, 4'($urandom), 1'b0, 1'b1, 4'b0000, -1);
        end

        for (int n = 0; n < 10 && req != 4'b0000; n++)
            do_txn(2, 4'b0000, 1'b0, 1'b0, 4'b0000, -1);

        // DMA drops req right after grant; stray completions in DONE and IDLE are ignored
        do_txn(3, 4'b0000, 1'b1, 1'b0, 4'b0001, -1);
        mem_done = 1'b1; mem_dout = 8'hC3;
        @(negedge clk_sys);
        @(negedge clk_sys);
        mem_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray_busy", busy, 0); chk("stray_strobe", {mem_we, mem_rd}, 0);
            chk("stray_ack", ack, 0);   chk("stray_rdata", rdata, m_rdata);
            @(negedge clk_sys);
        end

        // All four held: CPU wins once it has been passed over STARVE_LIMIT times
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0; exp_order[4] = 3;
        for (int n = 0; n < 5; n++) begin
            do_txn(2, 4'b0111, 1'b0, 1'b0, 4'b1111, -1);
            chk("starve_order", grant_id, exp_order[n]);
        end
        do_txn(1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1);
        chk("post_cpu_grant", grant_id, 0);
        for (int n = 0; n < 6 && req != 4'b0000; n++)
            do_txn(1, 4'b0000, 1'b0, 1'b0, 4'b0000, -1);

        repeat (3) @(negedge clk_sys);
        chk("sb_empty", sb.size(), 0);
        finish_up();
    end
endmodule
